// File: rtl/cd_rx_pages_if.sv
// cd_rx_pages_if: bundle of the frame-assembler write side and the CSR read
// side of the paged receive buffer.
//   wr_byte/wr_addr/wr_en   byte writes into the page being assembled
//   wr_err/wr_len/switch    error mark, frame length and commit pulse
//   switch_fail             one-cycle pulse when a commit is dropped
//   rd_en/rd_addr/rd_byte   registered read of the oldest completed frame
//   rd_len/rd_err           metadata of the oldest completed frame
//   rd_done/rd_done_all     release oldest / all completed frames
//   unread/unread_cnt       queue occupancy
//   lost_cnt                saturating count of dropped frames
// Modport master drives the requests (assembler + CSR), slave is the buffer.
interface cd_rx_pages_if #(
  parameter int PAGE_NUM = 4,
  parameter int PAGE_AW  = 8
);
  localparam int CNT_W = $clog2(PAGE_NUM) + 1;

  logic [7:0]         wr_byte;
  logic [PAGE_AW-1:0] wr_addr;
  logic               wr_en;
  logic               wr_err;
  logic [PAGE_AW-1:0] wr_len;
  logic               switch;
  logic               switch_fail;
  logic               rd_en;
  logic [PAGE_AW-1:0] rd_addr;
  logic [7:0]         rd_byte;
  logic [PAGE_AW-1:0] rd_len;
  logic               rd_err;
  logic               rd_done;
  logic               rd_done_all;
  logic               unread;
  logic [CNT_W-1:0]   unread_cnt;
  logic [7:0]         lost_cnt;

  modport master (
    output wr_byte, wr_addr, wr_en, wr_err, wr_len, switch,
    output rd_en, rd_addr, rd_done, rd_done_all,
    input  switch_fail, rd_byte, rd_len, rd_err, unread, unread_cnt, lost_cnt
  );

  modport slave (
    input  wr_byte, wr_addr, wr_en, wr_err, wr_len, switch,
    input  rd_en, rd_addr, rd_done, rd_done_all,
    output switch_fail, rd_byte, rd_len, rd_err, unread, unread_cnt, lost_cnt
  );
endinterface

// File: rtl/cd_rx_pages.sv
// cd_rx_pages: PAGE_NUM-page receive frame buffer for the CDBUS datapath.
// The assembler owns one write page; a commit (switch) appends that page to
// an in-order queue of completed frames, the CSR side reads and releases the
// oldest one. At most PAGE_NUM-1 frames are queued; further commits are
// dropped and counted in lost_cnt.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset (RAM contents are kept)
//   bus      cd_rx_pages_if slave modport (write, commit, read, release)
module cd_rx_pages #(
  parameter int PAGE_NUM = 4,
  parameter int PAGE_AW  = 8,
  parameter int CNT_W    = $clog2(PAGE_NUM) + 1
) (
  input  logic         clk,
  input  logic         reset_n,
  cd_rx_pages_if.slave bus
);
  localparam int PW    = $clog2(PAGE_NUM);
  localparam int DEPTH = PAGE_NUM << PAGE_AW;

  logic [7:0]         mem [DEPTH];
  logic [PAGE_AW-1:0] len_q [PAGE_NUM];
  logic               err_q [PAGE_NUM];

  logic [PW-1:0]      wp;
  logic [PW-1:0]      rp;
  logic [CNT_W-1:0]   cnt;
  logic               cur_err;
  logic [7:0]         lost_q;
  logic               fail_q;
  logic [7:0]         rd_q;

  logic release_one;
  logic releasing;
  logic full;
  logic accept;
  logic refuse;

  // A release in the same cycle frees a slot, so a commit against a full
  // queue still succeeds when the host is releasing at the same time.
  assign release_one = bus.rd_done & (cnt != '0) & ~bus.rd_done_all;
  assign releasing   = bus.rd_done_all | (bus.rd_done & (cnt != '0));
  assign full        = (cnt == CNT_W'(PAGE_NUM - 1)) & ~releasing;
  assign accept      = bus.switch & ~full;
  assign refuse      = bus.switch & full;

  // Byte storage: writes only ever target the page being assembled.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem[{wp, bus.wr_addr}] <= bus.wr_byte;
    end
  end

  // Registered read port; holds its value while rd_en is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= 8'h00;
    end else if (bus.rd_en) begin
      rd_q <= mem[{rp, bus.rd_addr}];
    end
  end

  // Page pointers, occupancy, metadata and loss accounting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      cur_err <= 1'b0;
      lost_q  <= 8'h00;
      fail_q  <= 1'b0;
      for (int i = 0; i < PAGE_NUM; i++) begin
        len_q[i] <= '0;
        err_q[i] <= 1'b0;
      end
    end else begin
      fail_q <= refuse;

      if (accept) begin
        len_q[wp] <= bus.wr_len;
        err_q[wp] <= cur_err | bus.wr_err;
        wp        <= wp + PW'(1);
      end

      // The error mark belongs to the frame under assembly; any commit,
      // accepted or dropped, starts a fresh frame.
      if (bus.switch) begin
        cur_err <= 1'b0;
      end else if (bus.wr_err) begin
        cur_err <= 1'b1;
      end

      // Releasing everything jumps rp to the current write page, which is
      // exactly where a simultaneous commit lands, leaving that frame queued.
      if (bus.rd_done_all) begin
        rp     <= wp;
        cnt    <= accept ? CNT_W'(1) : '0;
        lost_q <= 8'h00;
      end else begin
        if (release_one) begin
          rp <= rp + PW'(1);
        end
        cnt <= cnt + CNT_W'(accept) - CNT_W'(release_one);
        if (refuse && (lost_q != 8'hFF)) begin
          lost_q <= lost_q + 8'd1;
        end
      end
    end
  end

  assign bus.rd_byte     = rd_q;
  assign bus.rd_len      = len_q[rp];
  assign bus.rd_err      = err_q[rp];
  assign bus.unread      = (cnt != '0);
  assign bus.unread_cnt  = cnt;
  assign bus.lost_cnt    = lost_q;
  assign bus.switch_fail = fail_q;
endmodule
